// File: rtl/dac_sample_scheduler.sv
// Sample-rate scheduler for the 8-bit parallel DAC: programmable slot divider,
// DAC_CLK strobe generation and two-producer arbitration with underrun hold.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | enable low: counter parked at 0, strobe low, no readys, code held
// RUN   | counting slots 0..div_q; transfer or underrun on the tick cycle
module dac_sample_scheduler #(
  parameter int         DIV_W     = 16,
  parameter logic [7:0] IDLE_CODE = 8'h80,
  parameter int         UNDER_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [DIV_W-1:0]   rate_div,
  input  logic               rr_mode,
  input  logic [7:0]         in0_data,
  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [7:0]         in1_data,
  input  logic               in1_valid,
  output logic               in1_ready,
  output logic [7:0]         out_dac_data,
  output logic               out_dac_clk,
  output logic [1:0]         out_grant,
  output logic [UNDER_W-1:0] out_underrun
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [7:0]         dac_data_q, dac_data_d;
  logic               dac_clk_q, dac_clk_d;
  logic [1:0]         grant_q, grant_d;
  logic               last_q, last_d;   // 1 = ch1 won the last granted slot
  logic [UNDER_W-1:0] under_q, under_d;

  logic [DIV_W-1:0] rate_eff;
  logic [DIV_W:0]   half;
  logic             tick;
  logic             pick0;
  logic             pick1;

  assign rate_eff = (rate_div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : rate_div;
  assign half     = ({1'b0, div_q} + 1'b1) >> 1;
  assign tick     = (state_q == ST_RUN) && enable && (cnt_q == div_q);

  // ch0 wins unless ch1 alone is valid, or round-robin says it is ch1's turn
  assign pick0 = in0_valid && (!in1_valid || !rr_mode || last_q);
  assign pick1 = in1_valid && !pick0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= {{(DIV_W-1){1'b0}}, 1'b1};
      dac_data_q <= IDLE_CODE;
      dac_clk_q  <= 1'b0;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      under_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      dac_data_q <= dac_data_d;
      dac_clk_q  <= dac_clk_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      under_q    <= under_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    dac_data_d = dac_data_q;
    grant_d    = grant_q;
    last_d     = last_q;
    under_d    = under_q;
    in0_ready  = tick && pick0;
    in1_ready  = tick && pick1;

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (enable) div_d = rate_eff;
    end else if (!enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      div_d = rate_eff;
      if (pick0) begin
        dac_data_d = in0_data;
        grant_d    = 2'b01;
        last_d     = 1'b0;
      end else if (pick1) begin
        dac_data_d = in1_data;
        grant_d    = 2'b10;
        last_d     = 1'b1;
      end else begin
        grant_d = 2'b00;
        if (under_q != '1) under_d = under_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // strobe follows the counter value it will hold next, so it is low at slot start
    dac_clk_d = (state_d == ST_RUN) && ({1'b0, cnt_d} >= half);
  end

  assign out_dac_data = dac_data_q;
  assign out_dac_clk  = dac_clk_q;
  assign out_grant    = grant_q;
  assign out_underrun = under_q;

endmodule
